// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_pkg
//  Purpose  : Shared encodings and helpers for the sub-word SIMD shift
//             sequencer: op / element-width codes, controller state type and
//             per-width element geometry functions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package shift_seq_pkg;

  // Shift operation codes
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Element width codes
  localparam logic [1:0] WW_B = 2'b00;
  localparam logic [1:0] WW_H = 2'b01;
  localparam logic [1:0] WW_W = 2'b10;
  localparam logic [1:0] WW_D = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of elements packed into a 64-bit operand
  function automatic logic [3:0] elem_count(input logic [1:0] ww);
    case (ww)
      WW_B:    return 4'd8;
      WW_H:    return 4'd4;
      WW_W:    return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  // Significant shift-amount bits: log2 of the element width
  function automatic logic [5:0] amt_mask(input logic [1:0] ww);
    case (ww)
      WW_B:    return 6'd7;
      WW_H:    return 6'd15;
      WW_W:    return 6'd31;
      default: return 6'd63;
    endcase
  endfunction

  // All-ones mask covering one element, right-justified
  function automatic logic [63:0] elem_mask(input logic [1:0] ww);
    case (ww)
      WW_B:    return 64'h0000_0000_0000_00FF;
      WW_H:    return 64'h0000_0000_0000_FFFF;
      WW_W:    return 64'h0000_0000_FFFF_FFFF;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Bit offset of element idx (W*idx); idx bits beyond the element count
  // for the given width are ignored
  function automatic logic [5:0] elem_offset(input logic [1:0] ww,
                                             input logic [2:0] idx);
    case (ww)
      WW_B:    return {idx, 3'b000};
      WW_H:    return {idx[1:0], 4'b0000};
      WW_W:    return {idx[0], 5'b00000};
      default: return 6'd0;
    endcase
  endfunction

  // Distance that left-aligns an element to the top of the doubleword (64-W)
  function automatic logic [5:0] align_shift(input logic [1:0] ww);
    case (ww)
      WW_B:    return 6'd56;
      WW_H:    return 6'd48;
      WW_W:    return 6'd32;
      default: return 6'd0;
    endcase
  endfunction

endpackage : shift_seq_pkg
`default_nettype wire

// File: rtl/shift_elem_lane.sv
`default_nettype none
// ============================================================================
//  Module   : shift_elem_lane
//  Purpose  : Combinational single-element shift lane. Extracts element idx
//             of opa, left-aligns it in a 64-bit word, derives the signed
//             shift amount from the matching element of opb, runs it through
//             a two's-complement-controlled doubleword shifter and returns
//             the top W bits right-justified.
//  Ports    : op, ww     - operation / element-width codes
//             idx        - element index to process
//             opa, opb   - latched data operand and per-element amounts
//             elem_res   - shifted element, right-justified, zeros above
//  Revision : 1.0  initial release
// ============================================================================
module shift_elem_lane
  import shift_seq_pkg::*;
#(
  parameter int SH_W = 7
) (
  input  logic [1:0]  op,
  input  logic [1:0]  ww,
  input  logic [2:0]  idx,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] elem_res
);

  logic [5:0]      w_off;
  logic [5:0]      w_align;
  logic [63:0]     w_opa_sh;
  logic [63:0]     w_opb_sh;
  logic [63:0]     w_sh_data;
  logic [5:0]      w_amt;
  logic [SH_W-1:0] w_sh;
  logic            w_data_tc;
  logic [SH_W-1:0] w_mag;
  logic [63:0]     w_sh_out;

  // Element extract, align and shifter control
  always_comb begin
    w_off     = elem_offset(ww, idx);
    w_align   = align_shift(ww);
    w_opa_sh  = opa >> w_off;
    w_opb_sh  = opb >> w_off;
    // Shifting the element up by 64-W drops the neighbours above and leaves
    // zeros below, giving the left-aligned shifter input directly.
    w_sh_data = w_opa_sh << w_align;
    w_amt     = w_opb_sh[5:0] & amt_mask(ww);
    w_sh      = '0;
    w_data_tc = 1'b0;
    case (op)
      OP_SLL: begin
        w_sh      = SH_W'({1'b0, w_amt});
        w_data_tc = 1'b0;
      end
      OP_SRL: begin
        w_sh      = SH_W'(0) - SH_W'({1'b0, w_amt});
        w_data_tc = 1'b0;
      end
      OP_SRA: begin
        w_sh      = SH_W'(0) - SH_W'({1'b0, w_amt});
        w_data_tc = 1'b1;
      end
      default: begin
        w_sh      = '0;
        w_data_tc = 1'b0;
      end
    endcase
  end

  // Doubleword shifter, arithmetic mode with two's-complement amount:
  // non-negative sh shifts left with zero fill, negative sh shifts right by
  // |sh| with sign fill when data_tc is set. |sh| never exceeds 63.
  always_comb begin
    w_mag    = SH_W'(0) - w_sh;
    w_sh_out = w_sh_data;
    if (!w_sh[SH_W-1]) begin
      w_sh_out = w_sh_data << w_sh[5:0];
    end else if (w_data_tc) begin
      w_sh_out = $unsigned($signed(w_sh_data) >>> w_mag[5:0]);
    end else begin
      w_sh_out = w_sh_data >> w_mag[5:0];
    end
    // Top W bits of the shifter output, brought back to bit 0
    elem_res = w_sh_out >> w_align;
  end

endmodule : shift_elem_lane
`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : shift_seq_ctrl
//  Purpose  : Multi-cycle sub-word SIMD shift controller. Accepts a request
//             over valid/ready, shifts one element per cycle (two with the
//             dual-lane option) through a shared doubleword shifter, and holds
//             the assembled 64-bit result until the consumer takes it.
//  Config   : SHIFT_SEQ_DUAL_LANE_EN - when defined, a second lane handles
//             element 2k+1 alongside 2k, halving RUN length. Results are
//             identical in both builds.
//  Ports    : clk, reset          - clock, asynchronous active-high reset
//             in_valid / in_ready - request handshake
//             in_op, in_ww        - operation and element-width codes
//             in_opa, in_opb      - data operand and per-element amounts
//             out_valid/out_ready - result handshake
//             out_data            - shifted result
//  Revision : 1.0  initial release
// ============================================================================
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SH_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [1:0]        in_ww,
  input  logic [DATA_W-1:0] in_opa,
  input  logic [DATA_W-1:0] in_opb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  state_e            r_state;
  logic [2:0]        r_idx;
  logic [1:0]        r_op;
  logic [1:0]        r_ww;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_result;

  logic [DATA_W-1:0] w_lane0_res;
  logic [DATA_W-1:0] w_lane1_res;
  logic              w_lane1_en;
  logic [2:0]        w_idx1;
  logic [DATA_W-1:0] w_emask;
  logic [DATA_W-1:0] w_next_result;
  logic [3:0]        w_count;
  logic              w_last;

  assign w_idx1  = r_idx + 3'd1;
  assign w_count = elem_count(r_ww);
  assign w_emask = elem_mask(r_ww);

  shift_elem_lane #(
    .SH_W (SH_W)
  ) u_lane0 (
    .op       (r_op),
    .ww       (r_ww),
    .idx      (r_idx),
    .opa      (r_opa),
    .opb      (r_opb),
    .elem_res (w_lane0_res)
  );

`ifdef SHIFT_SEQ_DUAL_LANE_EN
  localparam logic [2:0] IDX_STEP = 3'd2;

  shift_elem_lane #(
    .SH_W (SH_W)
  ) u_lane1 (
    .op       (r_op),
    .ww       (r_ww),
    .idx      (w_idx1),
    .opa      (r_opa),
    .opb      (r_opb),
    .elem_res (w_lane1_res)
  );

  // The odd lane sits idle when element 2k+1 does not exist (dword case)
  assign w_lane1_en = ({1'b0, w_idx1} < w_count);
`else
  localparam logic [2:0] IDX_STEP = 3'd1;

  assign w_lane1_res = '0;
  assign w_lane1_en  = 1'b0;
`endif

  // Last RUN cycle once this step covers the final element
  assign w_last = (({1'b0, r_idx} + {1'b0, IDX_STEP}) >= w_count);

  // The result register is cleared at accept and each element is written
  // exactly once, so OR-merging into place is sufficient.
  always_comb begin
    w_next_result = r_result
                  | ((w_lane0_res & w_emask) << elem_offset(r_ww, r_idx));
    if (w_lane1_en) begin
      w_next_result = w_next_result
                    | ((w_lane1_res & w_emask) << elem_offset(r_ww, w_idx1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= 3'd0;
      r_op     <= OP_SLL;
      r_ww     <= WW_B;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op     <= in_op;
            r_ww     <= in_ww;
            r_opa    <= in_opa;
            r_opb    <= in_opb;
            r_result <= '0;
            r_idx    <= 3'd0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_result <= w_next_result;
          if (w_last) begin
            r_idx   <= 3'd0;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + IDX_STEP;
          end
        end
        ST_DONE: begin
          // No accept here even with in_valid high; IDLE must be seen first
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_data  = r_result;

endmodule : shift_seq_ctrl
`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_seq_ctrl
//  Purpose  : Self-checking bench for shift_seq_ctrl: directed cases, back-
//             pressure, reset mid-RUN and randomized requests compared with
//             an element-by-element arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_shift_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [1:0]  in_ww;
  logic [63:0] in_opa;
  logic [63:0] in_opb;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;

  int n_checks;
  int n_errors;

  shift_seq_ctrl #(
    .DATA_W (64),
    .SH_W   (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_ww     (in_ww),
    .in_opa    (in_opa),
    .in_opb    (in_opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
    end
  endtask

  // Reference: treat each element as an integer of W bits and apply the
  // shift with ordinary arithmetic.
  function automatic logic [63:0] ref_shift(input logic [1:0] op,
                                            input logic [1:0] ww,
                                            input logic [63:0] a,
                                            input logic [63:0] b);
    int          w;
    int          n;
    int          amt;
    logic [63:0] mask;
    logic [63:0] e;
    logic [63:0] r;
    logic [63:0] res;
    w    = 8 << ww;
    n    = 64 / w;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    res  = '0;
    for (int i = 0; i < n; i++) begin
      e   = (a >> (w * i)) & mask;
      amt = int'((b >> (w * i)) & 64'(w - 1));
      case (op)
        2'b00: r = (e << amt) & mask;
        2'b01: r = e >> amt;
        2'b10: begin
          if (e[w-1]) e = e | ~mask;
          r = $unsigned($signed(e) >>> amt) & mask;
        end
        default: r = e;
      endcase
      res = res | (r << (w * i));
    end
    return res;
  endfunction

  function automatic int exp_lat(input logic [1:0] ww);
    int n;
    n = 8 >> ww;
`ifdef SHIFT_SEQ_DUAL_LANE_EN
    return (n + 1) / 2;
`else
    return n;
`endif
  endfunction

  // Starts at a negedge; returns at the negedge after the accept edge with
  // in_valid dropped and the request inputs scrambled.
  task automatic send(input logic [1:0] op, input logic [1:0] ww,
                      input logic [63:0] a, input logic [63:0] b);
    bit ok;
    ok       = 1'b0;
    in_op    = op;
    in_ww    = ww;
    in_opa   = a;
    in_opb   = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_ww    = 2'($urandom);
    in_opa   = {$urandom, $urandom};
    in_opb   = {$urandom, $urandom};
  endtask

  // Called at the negedge right after the accept edge
  task automatic wait_result(input string tag, input int lat,
                             input logic [63:0] exp);
    int cnt;
    cnt = 0;
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    while (!out_valid && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, 64'(cnt), 64'(lat));
    chk({tag, "_data"}, out_data, exp);
  endtask

  task automatic hold(input string tag, input int cycles,
                      input logic [63:0] exp);
    for (int h = 0; h < cycles; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_vld"}, 64'(out_valid), 64'd0);
  endtask

  task automatic run_case(input string tag, input logic [1:0] op,
                          input logic [1:0] ww, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp,
                          input int hold_cycles);
    send(op, ww, a, b);
    wait_result(tag, exp_lat(ww), exp);
    hold(tag, hold_cycles, exp);
    drain(tag);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [1:0]  r_ww;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] nop_a;
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_ww     = 2'b00;
    in_opa    = '0;
    in_opb    = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_case("b_sll", 2'b00, 2'b00, 64'h0102040810204080,
             64'h0101010101010101, 64'h0204081020408000, 0);
    run_case("h_sra", 2'b10, 2'b01, 64'h80007FFFF0F00001,
             64'h000F000400040001, 64'hFFFF07FFFF0F0000, 1);
    run_case("b_srl_mask", 2'b01, 2'b00, 64'hFFFFFFFFFFFFFFFF,
             64'h0909090909090909, 64'h7F7F7F7F7F7F7F7F, 0);
    run_case("d_srl_mask", 2'b01, 2'b11, 64'h8000000000000000,
             64'hFFFFFFFFFFFFFF3F, 64'h0000000000000001, 0);
    nop_a = 64'h123456789ABCDEF0;
    run_case("w_nop", 2'b11, 2'b10, nop_a, {$urandom, $urandom}, nop_a, 0);

    // Backpressure with a new request already waiting in DONE
    send(2'b00, 2'b00, 64'h0102040810204080, 64'h0101010101010101);
    wait_result("bp", exp_lat(2'b00), 64'h0204081020408000);
    in_op    = 2'b10;
    in_ww    = 2'b01;
    in_opa   = 64'h80007FFFF0F00001;
    in_opb   = 64'h000F000400040001;
    in_valid = 1'b1;
    hold("bp", 5, 64'h0204081020408000);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_opa   = {$urandom, $urandom};
    wait_result("bp_next", exp_lat(2'b01), 64'hFFFF07FFFF0F0000);
    drain("bp_next");

    // Reset while the byte sequence is at element 3
    send(2'b00, 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    run_case("after_rst", 2'b01, 2'b01, 64'hF0F0F0F012345678,
             64'h0004000800010000,
             ref_shift(2'b01, 2'b01, 64'hF0F0F0F012345678,
                       64'h0004000800010000), 0);

    // Randomized requests
    for (int k = 0; k < 40; k++) begin
      r_op = 2'($urandom);
      r_ww = 2'($urandom);
      r_a  = {$urandom, $urandom};
      r_b  = {$urandom, $urandom};
      if (k % 4 == 0) r_a[63] = 1'b1;
      run_case($sformatf("rnd%0d_op%0d_ww%0d", k, r_op, r_ww), r_op, r_ww,
               r_a, r_b, ref_shift(r_op, r_ww, r_a, r_b),
               int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_shift_seq_ctrl
`default_nettype wire

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle controller that runs sub-word SIMD shifts (SLL/SRL/SRA on byte/half/word/dword elements) through a single shared 64-bit doubleword shifter (DW_shifter_doubleword).
- Sits in the CPU execute stage beside the ALU and is started by a valid/ready handshake from issue.
- Processes one element per cycle, assembles the 64-bit result, and holds it until writeback accepts it.

Parameters:
- DATA_W, 64, operand/result width; only 64 is supported.
- SH_W, 7, shifter amount width (two's-complement, sign bit = bit 6).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  controller idle, can accept
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 NOP (shift by 0)
- in_ww  in  2  element width: 00 byte, 01 half, 10 word, 11 dword
- in_opa  in  64  data operand
- in_opb  in  64  per-element shift amounts
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  64  shifted result

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-high, port named reset.
- Reset values: state IDLE; in_ready=1; out_valid=0; out_data=0; index=0.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch op/ww/opa/opb, clear the result register, set index=0, go to RUN.
  - RUN: in_ready=0. Process element[index] each cycle. After the last element (index=N-1, N=8/4/2/1 for ww=00/01/10/11), go to DONE.
  - DONE: out_valid=1, out_data stable. When out_ready=1, go to IDLE.
- Handshake timing:
  - Acceptance happens at the clock edge where IDLE && in_valid.
  - out_valid rises exactly N edges after the accept edge: byte 8, half 4, word 2, dword 1.
- Element mapping:
  - Element i occupies bits [W*i+W-1 : W*i]; elements are processed i=0 upward.
  - Shift amount = low log2(W) bits of element i of opb (byte 3, half 4, word 5, dword 6). Upper bits are ignored.
- Shifter control for element i:
  - Data input: element left-aligned at [63:64-W], zeros below. sh_mode=1, sh_tc=1.
  - SLL: sh=+amt, data_tc=0.
  - SRL: sh=-amt, data_tc=0.
  - SRA: sh=-amt, data_tc=1.
  - NOP: sh=0.
  - Result element = shifter output [63:64-W], written into the result register at element i.
  - amt=0 gives an identity result; the maximum amount is 63, so sh=-63 is legal.
- DONE with in_valid=1: no accept in the same cycle. IDLE is entered on the next edge, and acceptance happens the following cycle.
- Backpressure: while out_ready=0 in DONE, out_data/out_valid hold indefinitely.
- Reset asserted mid-RUN or mid-DONE: immediately return to reset values; the partial result is discarded and no out_valid is produced.
- Inputs are sampled only at the accept edge; changes afterwards are ignored.

Optional Feature:
- Macro: SHIFT_SEQ_DUAL_LANE_EN.
- Defined:
  - Two shifter lanes process elements 2k and 2k+1 in the same cycle.
  - RUN lasts ceil(N/2) cycles: byte 4, half 2, word 1, dword 1. The dword case uses lane 0 only.
- Undefined: single lane, N cycles as above.
- Results are bit-identical in both builds.

Decomposition:
- Package shift_seq_pkg:
  - op encodings (OP_SLL/OP_SRL/OP_SRA/OP_NOP)
  - ww encodings (WW_B/WW_H/WW_W/WW_D)
  - state enum (ST_IDLE/ST_RUN/ST_DONE)
  - functions elem_count(ww) and amt_mask(ww)
- Sub-module shift_elem_lane: combinational. Performs element extract/align, amount sign selection, the shifter instance and top-W extraction. Instantiated once, or twice under SHIFT_SEQ_DUAL_LANE_EN.

Test Plan:
- Byte SLL: opa=0x0102040810204080, opb=0x0101010101010101, ww=00, op=SLL → out_data=0x0204081020408000; out_valid 8 edges after accept.
- Half SRA: opa=0x80007FFFF0F00001, opb=0x000F000400040001, ww=01 → out_data=0xFFFF07FFFF0F0000; 4-cycle latency.
- Amount masking:
  - byte SRL, opa=0xFFFFFFFFFFFFFFFF, opb=0x0909090909090909 → 0x7F7F7F7F7F7F7F7F.
  - dword SRL, opa=0x8000000000000000, opb=0xFFFFFFFFFFFFFF3F → 0x0000000000000001; out_valid 1 edge after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 → out_data stable, in_ready=0 throughout. After the out_ready pulse, in_ready=1 next cycle and the next request is accepted.
- Reset mid-RUN: assert reset at byte index 3 → out_valid=0, out_data=0, in_ready=1 immediately. The next request completes correctly.
- NOP word: opa=0x123456789ABCDEF0, ww=10, op=NOP → out_data equals opa after 2 cycles. With SHIFT_SEQ_DUAL_LANE_EN, the byte SLL case completes in 4 cycles with the same data.
